// File: rtl/ahbl_arb_pkg.sv
// Shared types and AHB-Lite encodings for the round-robin master arbiter.
package ahbl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // A 32-bit bus cannot carry more than a word per beat.
    function automatic logic [2:0] clamp_hsize(input logic [2:0] sz);
        return (sz > HSIZE_WORD) ? HSIZE_WORD : sz;
    endfunction

endpackage

// File: rtl/ahbl_rr_master_arbiter_if.sv
// Requester command bus plus AHB-Lite master signals; REQ_LOCK exists only
// when AHBL_ARB_LOCK_EN is defined.
interface ahbl_rr_master_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    REQ;
    logic [NUM_REQ*32-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]    REQ_WRITE;
    logic [NUM_REQ*3-1:0]  REQ_SIZE;
    logic [NUM_REQ*32-1:0] REQ_WDATA;
`ifdef AHBL_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    REQ_LOCK;
`endif
    logic [NUM_REQ-1:0]    ACK;
    logic                  ERR;
    logic [31:0]           RDATA;
    logic [NUM_REQ-1:0]    GNT;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
`ifdef AHBL_ARB_LOCK_EN
        input  REQ_LOCK,
`endif
        input  REQ, REQ_ADDR, REQ_WRITE, REQ_SIZE, REQ_WDATA,
        input  HRDATA, HREADY, HRESP,
        output ACK, ERR, RDATA, GNT,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
`ifdef AHBL_ARB_LOCK_EN
        output REQ_LOCK,
`endif
        output REQ, REQ_ADDR, REQ_WRITE, REQ_SIZE, REQ_WDATA,
        output HRDATA, HREADY, HRESP,
        input  ACK, ERR, RDATA, GNT,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

endinterface

// File: rtl/ahbl_rr_picker.sv
// Round-robin picker: first set request bit strictly after ptr_i, wrapping.
module ahbl_rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[IDX_W'(cand)]) begin
                found               = 1'b1;
                idx_o               = IDX_W'(cand);
                gnt_o[IDX_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahbl_rr_master_arbiter.sv
// Round-robin arbiter issuing one non-pipelined SINGLE/NONSEQ AHB-Lite transfer
// at a time. Define AHBL_ARB_LOCK_EN to enable locked back-to-back ownership.
module ahbl_rr_master_arbiter
    import ahbl_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input logic                      HCLK,
    input logic                      HRESET,
    ahbl_rr_master_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        haddr_q, haddr_d;
    logic [31:0]        hwdata_q, hwdata_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         htrans_q, htrans_d;
    logic               hwrite_q, hwrite_d;
    logic [2:0]         hsize_q, hsize_d;
    logic [3:0]         hprot_q;
    logic               hmastlock_q, hmastlock_d;

    logic [NUM_REQ-1:0] rr_onehot, win_onehot;
    logic [IDX_W-1:0]   rr_idx, win_idx;
    logic               win_lock;

    ahbl_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i (bus.REQ),
        .ptr_i (ptr_q),
        .gnt_o (rr_onehot),
        .idx_o (rr_idx)
    );

`ifdef AHBL_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic hold_lock;

    // ptr_q is the previous owner, so a still-locked owner bypasses rotation.
    assign hold_lock  = lock_q && bus.REQ[ptr_q] && bus.REQ_LOCK[ptr_q];
    assign win_idx    = hold_lock ? ptr_q : rr_idx;
    assign win_onehot = hold_lock ? (NUM_REQ'(1) << ptr_q) : rr_onehot;
    assign win_lock   = bus.REQ_LOCK[win_idx];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`else
    assign win_idx    = rr_idx;
    assign win_onehot = rr_onehot;
    assign win_lock   = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hprot_q     <= '0;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hprot_q     <= HPROT_VAL;
            hmastlock_q <= hmastlock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|bus.REQ)   state_d = ST_ADDR;
            ST_ADDR: if (bus.HREADY) state_d = ST_DATA;
            ST_DATA: if (bus.HREADY) state_d = ST_ACK;
            ST_ACK:                  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output and latched command field.
    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hmastlock_d = hmastlock_q;
`ifdef AHBL_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.REQ) begin
                    ptr_d       = win_idx;
                    gnt_d       = win_onehot;
                    haddr_d     = bus.REQ_ADDR[32*32'(win_idx) +: 32];
                    hwrite_d    = bus.REQ_WRITE[win_idx];
                    hsize_d     = clamp_hsize(bus.REQ_SIZE[3*32'(win_idx) +: 3]);
                    wdata_d     = bus.REQ_WDATA[32*32'(win_idx) +: 32];
                    htrans_d    = HTRANS_NONSEQ;
                    hmastlock_d = win_lock;
`ifdef AHBL_ARB_LOCK_EN
                    lock_d      = win_lock;
`endif
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    htrans_d    = HTRANS_IDLE;
                    hmastlock_d = 1'b0;
                    hwdata_d    = wdata_q;
                end
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    rdata_d = hwrite_q ? 32'h0 : bus.HRDATA;
                    err_d   = bus.HRESP;
                    ack_d   = gnt_q;
                end
            end
            ST_ACK: begin
                gnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: ;
        endcase
    end

    assign bus.ACK       = ack_q;
    assign bus.ERR       = err_q;
    assign bus.RDATA     = rdata_q;
    assign bus.GNT       = gnt_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = hprot_q;
    assign bus.HMASTLOCK = hmastlock_q;
    assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahbl_rr_master_arbiter.sv
// Self-checking bench for ahbl_rr_master_arbiter; inputs driven and outputs
// sampled on the falling edge, expectations from a transfer-level model.
module tb_ahbl_rr_master_arbiter;
    localparam int unsigned NUM = 4;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0]    m_addr  [NUM];
    logic           m_wr    [NUM];
    logic [2:0]     m_size  [NUM];
    logic [31:0]    m_wdata [NUM];
    logic [NUM-1:0] m_req;

    ahbl_rr_master_arbiter_if #(.NUM_REQ(NUM)) bus ();

    ahbl_rr_master_arbiter #(.NUM_REQ(NUM), .HPROT_VAL(4'b0011)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Winner = first requesting index after the previous owner, modulo NUM.
    function automatic int model_pick(input logic [NUM-1:0] req, input int last);
        for (int k = 1; k <= NUM; k++)
            if (req[(last + k) % NUM]) return (last + k) % NUM;
        return -1;
    endfunction

    task automatic cyc();
        @(negedge HCLK);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NUM; i++) begin
            m_addr[i]  = $urandom;
            m_wr[i]    = 1'($urandom);
            m_size[i]  = 3'($urandom);
            m_wdata[i] = $urandom;
            bus.REQ_ADDR[32*i +: 32]  = m_addr[i];
            bus.REQ_WRITE[i]          = m_wr[i];
            bus.REQ_SIZE[3*i +: 3]    = m_size[i];
            bus.REQ_WDATA[32*i +: 32] = m_wdata[i];
        end
        m_req   = 4'($urandom_range(1, 15));
        bus.REQ = m_req;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        bus.REQ    = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
`ifdef AHBL_ARB_LOCK_EN
        bus.REQ_LOCK = '0;
`endif
        cyc();
        cyc();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        bus.REQ_ADDR = '0; bus.REQ_WRITE = '0; bus.REQ_SIZE = '0; bus.REQ_WDATA = '0;
        HRESET = 1'b1; bus.REQ = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
`ifdef AHBL_ARB_LOCK_EN
        bus.REQ_LOCK = '0;
`endif
        cyc();
        checks++;
        if ({bus.ACK, bus.ERR, bus.RDATA, bus.GNT} !== 41'h0) begin
            failures++;
            $display("FAIL reset_req_side got=%h exp=0", {bus.ACK, bus.ERR, bus.RDATA, bus.GNT});
        end
        checks++;
        if ({bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HWDATA} !== 78'h0) begin
            failures++;
            $display("FAIL reset_ahb_side got=%h exp=0",
                     {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HWDATA});
        end
        cyc();
        HRESET = 1'b0;
        cyc();
        checks++;
        if ({bus.HPROT, bus.HBURST, bus.HTRANS, bus.GNT} !== {4'b0011, 3'b000, 2'b00, 4'b0000}) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", {bus.HPROT, bus.HBURST, bus.HTRANS, bus.GNT},
                     {4'b0011, 3'b000, 2'b00, 4'b0000});
        end
    endtask

    task automatic test_single_write();
        bus.REQ_ADDR[63:32] = 32'h0000_0010; bus.REQ_WRITE[1] = 1'b1;
        bus.REQ_SIZE[5:3] = 3'd2; bus.REQ_WDATA[63:32] = 32'hA5A5_0001;
        bus.REQ = 4'b0010;
        cyc();
        checks++;
        if ({bus.HTRANS, bus.GNT, bus.HADDR, bus.HWRITE, bus.HSIZE} !== {2'b10, 4'b0010, 32'h10, 1'b1, 3'd2}) begin
            failures++;
            $display("FAIL sw_addr_phase got=%h exp=%h", {bus.HTRANS, bus.GNT, bus.HADDR, bus.HWRITE, bus.HSIZE},
                     {2'b10, 4'b0010, 32'h10, 1'b1, 3'd2});
        end
        bus.REQ = '0;
        cyc();
        checks++;
        if ({bus.HTRANS, bus.HWDATA} !== {2'b00, 32'hA5A5_0001}) begin
            failures++;
            $display("FAIL sw_data_phase got=%h exp=%h", {bus.HTRANS, bus.HWDATA}, {2'b00, 32'hA5A5_0001});
        end
        cyc();
        checks++;
        if ({bus.ACK, bus.ERR} !== {4'b0010, 1'b0}) begin
            failures++;
            $display("FAIL sw_ack got=%h exp=%h", {bus.ACK, bus.ERR}, {4'b0010, 1'b0});
        end
        cyc();
        checks++;
        if ({bus.ACK, bus.GNT} !== 8'h00) begin
            failures++;
            $display("FAIL sw_after_ack got=%h exp=00", {bus.ACK, bus.GNT});
        end
    endtask

    task automatic test_read_wait();
        bus.REQ_ADDR[31:0] = 32'h20; bus.REQ_WRITE[0] = 1'b0; bus.REQ_SIZE[2:0] = 3'd2;
        bus.REQ = 4'b0001;
        cyc();
        checks++;
        if ({bus.HTRANS, bus.GNT, bus.HADDR, bus.HWRITE} !== {2'b10, 4'b0001, 32'h20, 1'b0}) begin
            failures++;
            $display("FAIL rd_addr_phase got=%h exp=%h", {bus.HTRANS, bus.GNT, bus.HADDR, bus.HWRITE},
                     {2'b10, 4'b0001, 32'h20, 1'b0});
        end
        cyc();
        bus.HREADY = 1'b0;
        cyc();
        checks++;
        if (bus.ACK !== 4'b0000) begin
            failures++;
            $display("FAIL rd_wait1 ack got=%b exp=0000", bus.ACK);
        end
        cyc();
        checks++;
        if (bus.ACK !== 4'b0000) begin
            failures++;
            $display("FAIL rd_wait2 ack got=%b exp=0000", bus.ACK);
        end
        bus.HREADY = 1'b1; bus.HRDATA = 32'h1234_5678;
        cyc();
        checks++;
        if ({bus.ACK, bus.ERR, bus.RDATA} !== {4'b0001, 1'b0, 32'h1234_5678}) begin
            failures++;
            $display("FAIL rd_ack got=%h exp=%h", {bus.ACK, bus.ERR, bus.RDATA}, {4'b0001, 1'b0, 32'h1234_5678});
        end
        bus.REQ = '0;
        cyc();
    endtask

    task automatic test_fairness();
        int             last;
        int             w;
        logic [NUM-1:0] exp_ack;
        logic [NUM-1:0] exp_gnt;
        do_reset();
        rand_fields();
        bus.REQ = 4'b1111;
        last    = NUM - 1;
        w       = 0;
        for (int c = 1; c <= 32; c++) begin
            cyc();
            if (c % 4 == 1) begin
                w    = model_pick(4'b1111, last);
                last = w;
            end
            exp_ack = (c % 4 == 3) ? 4'(4'b0001 << w) : 4'b0000;
            exp_gnt = (c % 4 != 0) ? 4'(4'b0001 << w) : 4'b0000;
            checks++;
            if ({bus.ACK, bus.GNT} !== {exp_ack, exp_gnt}) begin
                failures++;
                $display("FAIL fair_cycle%0d ack/gnt got=%b/%b exp=%b/%b", c, bus.ACK, bus.GNT, exp_ack, exp_gnt);
            end
        end
        bus.REQ = '0;
        cyc();
    endtask

    task automatic test_error();
        bus.REQ_ADDR[127:96] = 32'h40; bus.REQ_WRITE[3] = 1'b1; bus.REQ_SIZE[11:9] = 3'd2;
        bus.REQ = 4'b1000;
        cyc();
        checks++;
        if (bus.GNT !== 4'b1000) begin
            failures++;
            $display("FAIL err_gnt got=%b exp=1000", bus.GNT);
        end
        cyc();
        bus.HREADY = 1'b0; bus.HRESP = 1'b1;
        cyc();
        checks++;
        if (bus.ACK !== 4'b0000) begin
            failures++;
            $display("FAIL err_first_cycle ack got=%b exp=0000", bus.ACK);
        end
        bus.HREADY = 1'b1;
        cyc();
        checks++;
        if ({bus.ACK, bus.ERR} !== {4'b1000, 1'b1}) begin
            failures++;
            $display("FAIL err_ack got=%h exp=%h", {bus.ACK, bus.ERR}, {4'b1000, 1'b1});
        end
        bus.HRESP = 1'b0;
        bus.REQ_ADDR[95:64] = 32'h44; bus.REQ_WRITE[2] = 1'b0; bus.REQ_SIZE[8:6] = 3'd2;
        bus.REQ = 4'b0100; bus.HRDATA = 32'hCAFE_F00D;
        cyc();
        cyc();
        checks++;
        if ({bus.GNT, bus.HTRANS, bus.HADDR} !== {4'b0100, 2'b10, 32'h44}) begin
            failures++;
            $display("FAIL err_next_addr got=%h exp=%h", {bus.GNT, bus.HTRANS, bus.HADDR}, {4'b0100, 2'b10, 32'h44});
        end
        cyc();
        cyc();
        checks++;
        if ({bus.ACK, bus.ERR, bus.RDATA} !== {4'b0100, 1'b0, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL err_next_ack got=%h exp=%h", {bus.ACK, bus.ERR, bus.RDATA}, {4'b0100, 1'b0, 32'hCAFE_F00D});
        end
        bus.REQ = '0;
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.REQ_ADDR[63:32] = 32'h80; bus.REQ_WRITE[1] = 1'b1;
        bus.REQ = 4'b0010;
        cyc();
        cyc();
        bus.HREADY = 1'b0;
        #2 HRESET = 1'b1;
        #1;
        checks++;
        if ({bus.ACK, bus.GNT, bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE, bus.HPROT} !== 79'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {bus.ACK, bus.GNT, bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE, bus.HPROT});
        end
        cyc();
        checks++;
        if (bus.ACK !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_no_ack got=%b exp=0000", bus.ACK);
        end
        HRESET = 1'b0; bus.HREADY = 1'b1;
        bus.REQ = 4'b0011;
        cyc();
        checks++;
        if (bus.GNT !== 4'b0001) begin
            failures++;
            $display("FAIL mid_reset_first_winner got=%b exp=0001", bus.GNT);
        end
        cyc();
        cyc();
        checks++;
        if (bus.ACK !== 4'b0001) begin
            failures++;
            $display("FAIL mid_reset_ack got=%b exp=0001", bus.ACK);
        end
        bus.REQ = '0;
        cyc();
    endtask

    task automatic test_random();
        int          last;
        int          w;
        int          wa;
        int          wd;
        logic        err;
        logic [31:0] rd;
        logic [2:0]  exp_size;
        do_reset();
        last = NUM - 1;
        rand_fields();
        for (int t = 0; t < 40; t++) begin
            wa  = $urandom_range(0, 2);
            wd  = $urandom_range(0, 2);
            err = ($urandom_range(0, 3) == 0);
            rd  = $urandom;
            cyc();
            w        = model_pick(m_req, last);
            last     = w;
            exp_size = (m_size[w] > 3'd2) ? 3'd2 : m_size[w];
            checks++;
            if ({bus.GNT, bus.HTRANS, bus.HMASTLOCK, bus.HADDR, bus.HWRITE, bus.HSIZE} !==
                {4'(4'b0001 << w), 2'b10, 1'b0, m_addr[w], m_wr[w], exp_size}) begin
                failures++;
                $display("FAIL rnd%0d_addr got=%h exp=%h", t,
                         {bus.GNT, bus.HTRANS, bus.HMASTLOCK, bus.HADDR, bus.HWRITE, bus.HSIZE},
                         {4'(4'b0001 << w), 2'b10, 1'b0, m_addr[w], m_wr[w], exp_size});
            end
            bus.REQ = 4'($urandom);
            for (int a = 0; a < wa; a++) begin
                bus.HREADY = 1'b0;
                cyc();
                checks++;
                if ({bus.HTRANS, bus.HADDR} !== {2'b10, m_addr[w]}) begin
                    failures++;
                    $display("FAIL rnd%0d_addr_hold got=%h exp=%h", t, {bus.HTRANS, bus.HADDR}, {2'b10, m_addr[w]});
                end
            end
            bus.HREADY = 1'b1;
            cyc();
            checks++;
            if (bus.HTRANS !== 2'b00 || (m_wr[w] && bus.HWDATA !== m_wdata[w])) begin
                failures++;
                $display("FAIL rnd%0d_data got=%h/%h exp=00/%h", t, bus.HTRANS, bus.HWDATA, m_wdata[w]);
            end
            for (int d = 0; d < wd; d++) begin
                bus.HREADY = 1'b0;
                bus.HRESP  = err && (d == wd - 1);
                cyc();
                checks++;
                if (bus.ACK !== 4'b0000) begin
                    failures++;
                    $display("FAIL rnd%0d_wait_ack got=%b exp=0000", t, bus.ACK);
                end
            end
            bus.HREADY = 1'b1; bus.HRESP = err; bus.HRDATA = rd;
            cyc();
            checks++;
            if ({bus.ACK, bus.ERR, bus.RDATA} !== {4'(4'b0001 << w), err, m_wr[w] ? 32'h0 : rd}) begin
                failures++;
                $display("FAIL rnd%0d_ack got=%h exp=%h", t, {bus.ACK, bus.ERR, bus.RDATA},
                         {4'(4'b0001 << w), err, m_wr[w] ? 32'h0 : rd});
            end
            bus.HRESP = 1'b0;
            if (t < 39) rand_fields();
            else bus.REQ = '0;
            cyc();
            checks++;
            if ({bus.GNT, bus.HTRANS, bus.ACK} !== 10'h0) begin
                failures++;
                $display("FAIL rnd%0d_idle got=%h exp=0", t, {bus.GNT, bus.HTRANS, bus.ACK});
            end
        end
    endtask

`ifdef AHBL_ARB_LOCK_EN
    task automatic test_lock();
        logic [NUM-1:0] exp_gnt;
        do_reset();
        rand_fields();
        bus.REQ = 4'b1100; bus.REQ_LOCK = 4'b0100;
        for (int t = 0; t < 4; t++) begin
            exp_gnt = (t < 3) ? 4'b0100 : 4'b1000;
            cyc();
            checks++;
            if ({bus.GNT, bus.HMASTLOCK} !== {exp_gnt, (t < 3)}) begin
                failures++;
                $display("FAIL lock%0d_grant got=%h exp=%h", t, {bus.GNT, bus.HMASTLOCK}, {exp_gnt, (t < 3)});
            end
            cyc();
            cyc();
            checks++;
            if (bus.ACK !== exp_gnt) begin
                failures++;
                $display("FAIL lock%0d_ack got=%b exp=%b", t, bus.ACK, exp_gnt);
            end
            if (t == 2) begin
                bus.REQ = 4'b1000; bus.REQ_LOCK = '0;
            end
            if (t == 3) bus.REQ = '0;
            cyc();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_fairness();
        test_error();
        test_reset_mid();
        test_random();
`ifdef AHBL_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
